// File: rtl/clk_meter_pkg.sv
// Shared types and widths for the clock period meter.
package clk_meter_pkg;

    localparam int COUNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with rising-edge detect for an asynchronous input.
// Reusable for any asynchronous edge source (period meter, trigger input).
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic Reset,
    input  logic async_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low reset; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = s & ~r_s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of an asynchronous square wave in inclk cycles.
// Optional duty measurement (high_count) is enabled by defining CLK_METER_DUTY_EN.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               inclk,
    input  logic               Reset,
    input  logic               sig_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] period_count,
    output logic [COUNT_W-1:0] high_count,
    output logic               period_valid,
    output logic               timeout,
    output logic               busy
);

    localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

    meter_state_t       r_state;
    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] r_period;
    logic               r_update;
    logic               r_valid;
    logic               r_timeout;

    logic w_rise;
    logic w_in_measure;
    logic w_meas_rise;
    logic w_timeout_hit;

`ifdef CLK_METER_DUTY_EN
    logic w_s;
`else
    logic w_s_unused;
`endif

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (inclk),
        .Reset    (Reset),
        .async_in (sig_in),
`ifdef CLK_METER_DUTY_EN
        .s        (w_s),
`else
        .s        (w_s_unused),
`endif
        .rise     (w_rise)
    );

    // enable has priority over both the edge and the timeout check
    assign w_in_measure  = enable && (r_state == MEASURE);
    assign w_meas_rise   = w_in_measure && w_rise;
    assign w_timeout_hit = w_in_measure && !w_rise && (r_cnt == TIMEOUT_LAST);

    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_update  <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_update <= 1'b0;
            // valid trails the period register by a cycle so readers see a settled value
            r_valid  <= r_update;
            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: r_state <= ARM;
                    ARM: begin
                        if (w_rise) begin
                            r_cnt   <= '0;
                            r_state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (w_meas_rise) begin
                            r_period  <= r_cnt + 1'b1;
                            r_update  <= 1'b1;
                            r_timeout <= 1'b0;
                            r_cnt     <= '0;
                        end else if (w_timeout_hit) begin
                            r_timeout <= 1'b1;
                            r_period  <= '0;
                            r_cnt     <= '0;
                            r_state   <= ARM;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef CLK_METER_DUTY_EN
    logic [COUNT_W-1:0] r_hcnt;
    logic [COUNT_W-1:0] r_high;

    // hcnt clears whenever cnt does; the rise cycle itself is counted via the +1
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            r_hcnt <= '0;
            r_high <= '0;
        end else if (w_meas_rise) begin
            r_high <= r_hcnt + 1'b1;
            r_hcnt <= '0;
        end else if (w_timeout_hit) begin
            r_high <= '0;
            r_hcnt <= '0;
        end else if (!w_in_measure) begin
            r_hcnt <= '0;
        end else if (w_s) begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign high_count = r_high;
`else
    assign high_count = '0;
`endif

    assign period_count = r_period;
    assign period_valid = r_valid;
    assign timeout      = r_timeout;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: table-driven square waves plus
// hand-written enable, reset and timeout sequences.
module tb_clk_period_meter;

    localparam int SYNC_A = 2;
    localparam int SYNC_B = 3;
    localparam int TO_B   = 100;
    localparam int LAT_A  = SYNC_A + 2;
    localparam int QN     = 128;

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    logic        inclk;
    logic        Reset;
    logic        sig_a, en_a, sig_b, en_b;
    logic [31:0] pc_a, hc_a, pc_b, hc_b;
    logic        valid_a, to_a, busy_a, valid_b, to_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // pulses seen on dut_a, written only by the monitor
    int obs_p [QN];
    int obs_h [QN];
    int obs_c [QN];
    int obs_wr = 0;
    int n_valid_b = 0;

    // expected pulses, written only by the main sequence
    int exp_p [QN];
    int exp_h [QN];
    int exp_c [QN];
    int exp_wr = 0;
    int obs_rd = 0;
    bit meas_open = 0;
    int pend_p = 0;
    int pend_h = 0;

    clk_period_meter #(.SYNC_STAGES(SYNC_A)) dut_a (
        .inclk        (inclk),
        .Reset        (Reset),
        .sig_in       (sig_a),
        .enable       (en_a),
        .period_count (pc_a),
        .high_count   (hc_a),
        .period_valid (valid_a),
        .timeout      (to_a),
        .busy         (busy_a)
    );

    clk_period_meter #(.SYNC_STAGES(SYNC_B), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .inclk        (inclk),
        .Reset        (Reset),
        .sig_in       (sig_b),
        .enable       (en_b),
        .period_count (pc_b),
        .high_count   (hc_b),
        .period_valid (valid_b),
        .timeout      (to_b),
        .busy         (busy_b)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    always @(posedge inclk) cyc <= cyc + 1;

    always @(negedge inclk) begin
        if (valid_a) begin
            if (obs_wr < QN) begin
                obs_p[obs_wr] <= int'(pc_a);
                obs_h[obs_wr] <= int'(hc_a);
                obs_c[obs_wr] <= cyc;
            end
            obs_wr <= obs_wr + 1;
        end
        if (valid_b) n_valid_b <= n_valid_b + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int hexp(input int h);
`ifdef CLK_METER_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    // a rise driven now closes the period currently being driven
    task automatic push_exp();
        if (meas_open) begin
            exp_p[exp_wr] = pend_p;
            exp_h[exp_wr] = pend_h;
            exp_c[exp_wr] = cyc;
            exp_wr++;
        end
    endtask

    task automatic wave_a(input int hi, input int lo, input int ep, input int eh);
        @(negedge inclk);
        sig_a = 1'b1;
        push_exp();
        pend_p    = ep;
        pend_h    = eh;
        meas_open = 1'b1;
        repeat (hi - 1) @(negedge inclk);
        @(negedge inclk);
        sig_a = 1'b0;
        repeat (lo - 1) @(negedge inclk);
    endtask

    task automatic wave_b(input int hi, input int lo, output int t_rise);
        @(negedge inclk);
        sig_b  = 1'b1;
        t_rise = cyc;
        repeat (hi - 1) @(negedge inclk);
        @(negedge inclk);
        sig_b = 1'b0;
        repeat (lo - 1) @(negedge inclk);
    endtask

    task automatic drain();
        while (obs_rd < obs_wr && obs_rd < QN) begin
            if (obs_rd < exp_wr) begin
                check("period_count", obs_p[obs_rd], exp_p[obs_rd]);
                check("high_count", obs_h[obs_rd], hexp(exp_h[obs_rd]));
                check("valid latency", obs_c[obs_rd] - exp_c[obs_rd], LAT_A);
            end
            obs_rd++;
        end
        check("valid pulse count", obs_wr, exp_wr);
    endtask

    vec_t vecs [7];
    int   t_rise, t3, t_to, nv0;

    initial begin
        vecs[0] = '{hi: 4,   lo: 4,   n: 4, exp_p: 8,    exp_h: 4};
        vecs[1] = '{hi: 1,   lo: 1,   n: 6, exp_p: 2,    exp_h: 1};
        vecs[2] = '{hi: 500, lo: 500, n: 2, exp_p: 1000, exp_h: 500};
        vecs[3] = '{hi: 4,   lo: 4,   n: 3, exp_p: 8,    exp_h: 4};
        vecs[4] = '{hi: 6,   lo: 6,   n: 3, exp_p: 12,   exp_h: 6};
        vecs[5] = '{hi: 3,   lo: 4,   n: 3, exp_p: 7,    exp_h: 3};
        vecs[6] = '{hi: 4,   lo: 4,   n: 3, exp_p: 8,    exp_h: 4};

        Reset = 1'b0;
        sig_a = 1'b0; en_a = 1'b0; sig_b = 1'b0; en_b = 1'b0;

        // inputs wiggle while reset is held: nothing may move
        for (int i = 0; i < 6; i++) begin
            @(negedge inclk);
            sig_a = i[0]; en_a = ~i[0]; sig_b = i[0]; en_b = i[1];
        end
        @(negedge inclk);
        check("reset period_count", int'(pc_a), 0);
        check("reset high_count", int'(hc_a), 0);
        check("reset period_valid", int'(valid_a), 0);
        check("reset timeout", int'(to_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset busy b", int'(busy_b), 0);
        check("reset timeout b", int'(to_b), 0);
        sig_a = 1'b0; en_a = 1'b0; sig_b = 1'b0; en_b = 1'b0;
        @(negedge inclk);
        Reset = 1'b1;

        // continuous run through the table; first edge after arming is silent
        en_a = 1'b1;
        repeat (2) @(negedge inclk);
        check("busy after enable", int'(busy_a), 1);
        for (int v = 0; v < 7; v++)
            for (int k = 0; k < vecs[v].n; k++)
                wave_a(vecs[v].hi, vecs[v].lo, vecs[v].exp_p, vecs[v].exp_h);

        // disable in the low phase of a period
        @(negedge inclk);
        sig_a = 1'b1;
        push_exp();
        meas_open = 1'b0;
        repeat (3) @(negedge inclk);
        @(negedge inclk);
        sig_a = 1'b0;
        repeat (2) @(negedge inclk);
        en_a = 1'b0;
        repeat (6) @(negedge inclk);
        check("disable busy", int'(busy_a), 0);
        check("disable holds period", int'(pc_a), 8);
        check("disable holds high", int'(hc_a), hexp(4));
        drain();

        // re-enable: first edge re-arms, next edge measures
        en_a = 1'b1;
        repeat (3) @(negedge inclk);
        for (int k = 0; k < 3; k++) wave_a(4, 4, 8, 4);
        check("re-enable period", int'(pc_a), 8);
        wave_a(6, 6, 12, 6);

        // enable falls in the rise cycle of the edge closing the 12-cycle period
        meas_open = 1'b0;
        @(negedge inclk);
        sig_a = 1'b1;
        @(negedge inclk);
        @(negedge inclk);
        en_a = 1'b0;
        repeat (6) @(negedge inclk);
        sig_a = 1'b0;
        check("enable wins busy", int'(busy_a), 0);
        check("enable wins period", int'(pc_a), 8);
        drain();

        // asynchronous reset in the middle of a measurement
        en_a = 1'b1;
        repeat (3) @(negedge inclk);
        for (int k = 0; k < 3; k++) wave_a(4, 4, 8, 4);
        check("pre-reset period", int'(pc_a), 8);
        check("pre-reset busy", int'(busy_a), 1);
        #2 Reset = 1'b0;
        #1;
        check("async reset period", int'(pc_a), 0);
        check("async reset high", int'(hc_a), 0);
        check("async reset valid", int'(valid_a), 0);
        check("async reset busy", int'(busy_a), 0);
        meas_open = 1'b0;
        repeat (3) @(negedge inclk);
        en_a = 1'b0;
        Reset = 1'b1;
        repeat (4) @(negedge inclk);
        drain();

        // timeout on the short-timeout instance
        en_b = 1'b1;
        repeat (3) @(negedge inclk);
        nv0 = n_valid_b;
        wave_b(5, 5, t_rise);
        wave_b(5, 5, t_rise);
        wave_b(5, 5, t3);
        check("b pulses before timeout", n_valid_b - nv0, 2);
        check("b period", int'(pc_b), 10);
        check("b high", int'(hc_b), hexp(5));
        nv0  = n_valid_b;
        t_to = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge inclk);
            if (to_b) begin
                t_to = cyc;
                break;
            end
        end
        // rise acted on SYNC_B+1 edges after the drive, then TO_B counting edges
        check("timeout cycle", t_to, t3 + SYNC_B + 1 + TO_B);
        check("timeout period", int'(pc_b), 0);
        check("timeout high", int'(hc_b), 0);
        check("timeout rearms", int'(busy_b), 1);
        check("timeout no valid", n_valid_b - nv0, 0);

        wave_b(5, 5, t_rise);
        check("restart first edge silent", n_valid_b - nv0, 0);
        check("restart timeout held", int'(to_b), 1);
        wave_b(5, 5, t_rise);
        check("restart pulse", n_valid_b - nv0, 1);
        check("restart period", int'(pc_b), 10);
        check("restart high", int'(hc_b), hexp(5));
        check("restart timeout clear", int'(to_b), 0);
        en_b = 1'b0;
        repeat (4) @(negedge inclk);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
